// File: rtl/al_seq_div.sv
// al_seq_div -- iterative radix-2 restoring divider with per-operand signedness.
//
// Divides operand magnitudes one quotient bit per clock (MSB first), then
// applies sign correction in a single FIX cycle. Division is truncating:
// the remainder takes the sign of the dividend.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a divide (sampled only in IDLE)
//   signeda      1 = a is two's complement
//   signedb      1 = b is two's complement
//   a, b         dividend / divisor, sampled with start
//   busy         high while a divide is in progress
//   done         one-cycle pulse when results become valid
//   quotient     result quotient (held until the next FIX)
//   remainder    result remainder (held until the next FIX)
//   div_by_zero  set with done when b was 0, held with the results
module al_seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signeda,
  input  logic             signedb,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // state | meaning
  // IDLE  | waiting for start, results held
  // CALC  | one restoring-division step per clock
  // FIX   | sign correction / divide-by-zero substitution, pulse done
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] a_orig;
  logic             neg_q;
  logic             neg_r;
  logic             zero;
  logic [CNT_W-1:0] cnt;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    sa       = signeda & a[WIDTH-1];
    sb       = signedb & b[WIDTH-1];
    mag_a_in = sa ? -a : a;
    mag_b_in = sb ? -b : b;

    shifted  = {prem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, mag_b};
    // With shifted[WIDTH] set the shifted value already exceeds any WIDTH-bit
    // divisor, so the subtraction's sign bit is only meaningful otherwise.
    ge        = shifted[WIDTH] | ~trial[WIDTH];
    prem_next = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

    // After CALC, dvd has been fully replaced by quotient bits.
    q_fix = neg_q ? -dvd : dvd;
    r_fix = neg_r ? -prem : prem;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      prem        <= '0;
      mag_b       <= '0;
      a_orig      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd    <= mag_a_in;
            mag_b  <= mag_b_in;
            a_orig <= a;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            zero   <= (b == '0);
            prem   <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          prem <= prem_next;
          dvd  <= {dvd[WIDTH-2:0], ge};
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero) begin
            quotient    <= '1;
            remainder   <= a_orig;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_al_seq_div.sv
// Self-checking bench for al_seq_div (WIDTH=32): directed corner cases,
// randomized operands against an arithmetic reference model, start-while-busy,
// back-to-back operation and reset abort.
module tb_al_seq_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signeda;
  logic         signedb;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests_run    = 0;
  int tests_failed = 0;

  al_seq_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signeda    (signeda),
    .signedb    (signedb),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: truncating division on 64-bit integers, each operand
  // interpreted by its own signedness flag. Result is {q, r, div_by_zero}.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                           input logic sa_i, input logic sb_i);
    longint av;
    longint bv;
    longint qv;
    longint rv;
    if (b_i == '0) return {{W{1'b1}}, a_i, 1'b1};
    av = sa_i ? longint'($signed(a_i)) : longint'(a_i);
    bv = sb_i ? longint'($signed(b_i)) : longint'(b_i);
    qv = av / bv;
    rv = av % bv;
    return {W'(qv), W'(rv), 1'b0};
  endfunction

  // Must be called #1 after a rising edge. Issues one start pulse, then
  // scrambles the operand inputs and waits (bounded) for done.
  task automatic run_div(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         input logic sa_i, input logic sb_i,
                         output logic [2*W:0] res, output int lat,
                         output int busy_cyc, output logic [W-1:0] q_first);
    a = a_i; b = b_i; signeda = sa_i; signedb = sb_i; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; signeda = 1'($urandom); signedb = 1'($urandom);
    busy_cyc = busy ? 1 : 0;
    q_first  = quotient;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_cyc++;
    end
    res = {quotient, remainder, div_by_zero};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signeda = 1'b0; signedb = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
    end
    tests_run++;
    if ({quotient, remainder} !== '0) begin
      tests_failed++;
      $display("FAIL reset_results: q=%h r=%h required 0/0", quotient, remainder);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [7] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000,
                             32'h12345678, 32'h12345678, 32'd0};
    logic [W-1:0] vb [7] = '{32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd5};
    logic         vs [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2*W:0] res;
    logic [2*W:0] exp_res;
    logic [W-1:0] q_first;
    int lat;
    int busy_cyc;
    for (int i = 0; i < 7; i++) begin
      run_div(va[i], vb[i], vs[i], vs[i], res, lat, busy_cyc, q_first);
      exp_res = ref_div(va[i], vb[i], vs[i], vs[i]);
      tests_run++;
      if (res !== exp_res) begin
        tests_failed++;
        $display("FAIL directed_%0d: q/r/dbz=%h/%h/%b required %h/%h/%b", i,
                 res[2*W:W+1], res[W:1], res[0], exp_res[2*W:W+1], exp_res[W:1], exp_res[0]);
      end
      tests_run++;
      if (lat !== W + 1) begin
        tests_failed++;
        $display("FAIL directed_latency_%0d: %0d cycles required %0d", i, lat, W + 1);
      end
      tests_run++;
      if (busy_cyc !== W + 1) begin
        tests_failed++;
        $display("FAIL directed_busy_%0d: busy %0d cycles required %0d", i, busy_cyc, W + 1);
      end
    end
    // Spot-check the model itself on the plain unsigned case.
    exp_res = {32'd14, 32'd2, 1'b0};
    run_div(32'd100, 32'd7, 1'b0, 1'b0, res, lat, busy_cyc, q_first);
    tests_run++;
    if (res !== exp_res) begin
      tests_failed++;
      $display("FAIL unsigned_100_7: q/r/dbz=%h/%h/%b required 14/2/0",
               res[2*W:W+1], res[W:1], res[0]);
    end
  endtask

  task automatic test_random();
    logic [2*W:0] res;
    logic [2*W:0] exp_res;
    logic [W-1:0] q_first;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rsa;
    logic         rsb;
    int lat;
    int busy_cyc;
    int mode;
    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case (mode)
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 20));
        3:       rb = W'(0 - $urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rsa = 1'($urandom);
      rsb = 1'($urandom);
      run_div(ra, rb, rsa, rsb, res, lat, busy_cyc, q_first);
      exp_res = ref_div(ra, rb, rsa, rsb);
      tests_run++;
      if (res !== exp_res || lat !== W + 1) begin
        tests_failed++;
        $display("FAIL random_%0d a=%h b=%h sa=%b sb=%b: q/r/dbz=%h/%h/%b lat=%0d required %h/%h/%b lat=%0d",
                 i, ra, rb, rsa, rsb, res[2*W:W+1], res[W:1], res[0], lat,
                 exp_res[2*W:W+1], exp_res[W:1], exp_res[0], W + 1);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [2*W:0] exp_res;
    logic [2*W:0] res;
    int first_lat;
    int dones;
    exp_res = ref_div(32'd1000, 32'd7, 1'b0, 1'b0);
    res = '0;
    first_lat = -1;
    dones = 0;
    a = 32'd1000; b = 32'd7; signeda = 1'b0; signedb = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 10) begin
        a = 32'd5; b = 32'd1; signeda = 1'b1; signedb = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (first_lat < 0) begin
          first_lat = n;
          res = {quotient, remainder, div_by_zero};
        end
      end
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL ignore_start_pulses: %0d done pulses required 1", dones);
    end
    tests_run++;
    if (res !== exp_res || first_lat !== W + 1) begin
      tests_failed++;
      $display("FAIL ignore_start_result: q/r=%h/%h lat=%0d required %h/%h lat=%0d",
               res[2*W:W+1], res[W:1], first_lat, exp_res[2*W:W+1], exp_res[W:1], W + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W:0] res1;
    logic [2*W:0] res2;
    logic [2*W:0] exp1;
    logic [2*W:0] exp2;
    logic [W-1:0] q_first;
    int lat;
    int busy_cyc;
    exp1 = ref_div(32'hFFFFFF00, 32'd9, 1'b1, 1'b0);
    exp2 = ref_div(32'd123456, 32'hFFFFFFFD, 1'b0, 1'b1);
    run_div(32'hFFFFFF00, 32'd9, 1'b1, 1'b0, res1, lat, busy_cyc, q_first);
    tests_run++;
    if (res1 !== exp1) begin
      tests_failed++;
      $display("FAIL b2b_first: q/r=%h/%h required %h/%h",
               res1[2*W:W+1], res1[W:1], exp1[2*W:W+1], exp1[W:1]);
    end
    // Still inside the done cycle: this start must be accepted.
    run_div(32'd123456, 32'hFFFFFFFD, 1'b0, 1'b1, res2, lat, busy_cyc, q_first);
    tests_run++;
    if (q_first !== exp1[2*W:W+1]) begin
      tests_failed++;
      $display("FAIL b2b_hold: quotient=%h during second divide required %h",
               q_first, exp1[2*W:W+1]);
    end
    tests_run++;
    if (res2 !== exp2 || lat !== W + 1) begin
      tests_failed++;
      $display("FAIL b2b_second: q/r=%h/%h lat=%0d required %h/%h lat=%0d",
               res2[2*W:W+1], res2[W:1], lat, exp2[2*W:W+1], exp2[W:1], W + 1);
    end
  endtask

  task automatic test_reset_abort();
    logic [2*W:0] res;
    logic [2*W:0] exp_res;
    logic [W-1:0] q_first;
    int lat;
    int busy_cyc;
    int dones;
    a = 32'd5000; b = 32'd3; signeda = 1'b0; signedb = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      tests_failed++;
      $display("FAIL abort_async_clear: busy=%b done=%b dbz=%b q=%h r=%h required all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d done pulses required 0", dones);
    end
    exp_res = {32'd100, 32'd0, 1'b0};
    run_div(32'd1000, 32'd10, 1'b0, 1'b0, res, lat, busy_cyc, q_first);
    tests_run++;
    if (res !== exp_res || lat !== W + 1) begin
      tests_failed++;
      $display("FAIL abort_recover: q/r/dbz=%h/%h/%b lat=%0d required 100/0/0 lat=%0d",
               res[2*W:W+1], res[W:1], res[0], lat, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
